// File: rtl/mem_fetch_if.sv
// Bus bundle for mem_fetch_stage: upstream handshake, RAM and flash read ports,
// and the compositor output. modport master is the fetch stage, slave is its environment.
interface mem_fetch_if #(
  parameter int RAM_AW = 26
);
  // Every valid/ready pair transfers on a rising edge where both are 1; the
  // sender holds its payload stable until then. A req stays high with a stable
  // address until its ack is sampled high.
  logic              in_valid;
  logic              in_ready;
  logic              readRamEn;
  logic              readFlashEn;
  logic [7:0]        layerID;
  logic [RAM_AW-1:0] layerBase;
  logic [RAM_AW-1:0] ramAddressOffset;
  logic [29:0]       flashAddressBits;

  logic              ram_req;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_ack;
  logic [31:0]       ram_rdata;

  logic              flash_req;
  logic [26:0]       flash_addr;
  logic              flash_ack;
  logic [7:0]        flash_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_layerID;
  logic [31:0]       out_pixel;
  logic              out_fontBit;
  logic              out_drawn;
  logic              out_isText;
  logic              fetch_error;

  modport master (
    input  in_valid, readRamEn, readFlashEn, layerID, layerBase, ramAddressOffset,
           flashAddressBits, ram_ack, ram_rdata, flash_ack, flash_rdata, out_ready,
    output in_ready, ram_req, ram_addr, flash_req, flash_addr, out_valid,
           out_layerID, out_pixel, out_fontBit, out_drawn, out_isText, fetch_error
  );

  modport slave (
    output in_valid, readRamEn, readFlashEn, layerID, layerBase, ramAddressOffset,
           flashAddressBits, ram_ack, ram_rdata, flash_ack, flash_rdata, out_ready,
    input  in_ready, ram_req, ram_addr, flash_req, flash_addr, out_valid,
           out_layerID, out_pixel, out_fontBit, out_drawn, out_isText, fetch_error
  );
endinterface

// File: rtl/mem_fetch_stage.sv
// Memory fetch stage: reads a RAM pixel word and/or a flash font byte per item and
// presents the result to the compositor. Optional ack watchdog: FETCH_TIMEOUT_EN.
module mem_fetch_stage #(
  parameter int RAM_AW         = 26,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  mem_fetch_if.master bus,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RAM_WAIT   = 2'd1,
    FLASH_WAIT = 2'd2,
    OUT_HOLD   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              in_ready_c;
  logic              ram_req_c;
  logic              flash_req_c;
  logic              out_valid_c;
  logic              tmo;

  logic [RAM_AW-1:0] ram_addr_r;
  logic [26:0]       flash_addr_r;
  logic [2:0]        bit_sel;
  logic              ram_en_r;
  logic              flash_en_r;
  logic [7:0]        id_r;
  logic [31:0]       pixel_r;
  logic              font_r;
  logic              drawn_r;
  logic              text_r;
  logic              font_bit;

  // MSB-first bit select: bit (7 - sel) is bit ~sel for a 3-bit sel.
  assign font_bit = bus.flash_rdata[~bit_sel];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    ram_req_c   = 1'b0;
    flash_req_c = 1'b0;
    out_valid_c = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          if (bus.readRamEn)        state_next = RAM_WAIT;
          else if (bus.readFlashEn) state_next = FLASH_WAIT;
          else                      state_next = OUT_HOLD;
        end
      end
      RAM_WAIT: begin
        ram_req_c = 1'b1;
        if (bus.ram_ack) state_next = flash_en_r ? FLASH_WAIT : OUT_HOLD;
        else if (tmo)    state_next = OUT_HOLD;
      end
      FLASH_WAIT: begin
        flash_req_c = 1'b1;
        if (bus.flash_ack || tmo) state_next = OUT_HOLD;
      end
      OUT_HOLD: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Results start cleared at transfer so skipped or timed-out fetches read as 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr_r   <= '0;
      flash_addr_r <= '0;
      bit_sel      <= '0;
      ram_en_r     <= 1'b0;
      flash_en_r   <= 1'b0;
      id_r         <= '0;
      pixel_r      <= '0;
      font_r       <= 1'b0;
      drawn_r      <= 1'b0;
      text_r       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            ram_addr_r   <= bus.layerBase + bus.ramAddressOffset;
            flash_addr_r <= bus.flashAddressBits[29:3];
            bit_sel      <= bus.flashAddressBits[2:0];
            ram_en_r     <= bus.readRamEn;
            flash_en_r   <= bus.readFlashEn;
            id_r         <= bus.layerID;
            text_r       <= bus.readFlashEn;
            pixel_r      <= '0;
            font_r       <= 1'b0;
            drawn_r      <= 1'b0;
          end
        end
        RAM_WAIT: begin
          if (bus.ram_ack) begin
            pixel_r <= bus.ram_rdata;
            drawn_r <= !flash_en_r;
          end
        end
        FLASH_WAIT: begin
          if (bus.flash_ack) begin
            font_r  <= font_bit;
            drawn_r <= ram_en_r & font_bit;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;
  logic             err_r;

  assign waiting = (state == RAM_WAIT) || (state == FLASH_WAIT);
  assign tmo = ((state == RAM_WAIT && !bus.ram_ack) || (state == FLASH_WAIT && !bus.flash_ack))
               && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                wait_cnt <= '0;
    else if (!waiting || state_next != state) wait_cnt <= '0;
    else                                      wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    err_r <= 1'b0;
    else if (tmo) err_r <= 1'b1;
  end

  assign bus.fetch_error = err_r;
`else
  // Watchdog compiled out: the comparison is false for every legal limit.
  assign tmo             = (TIMEOUT_CYCLES < 0);
  assign bus.fetch_error = 1'b0;
`endif

  assign bus.in_ready    = in_ready_c;
  assign bus.ram_req     = ram_req_c;
  assign bus.flash_req   = flash_req_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.ram_addr    = ram_addr_r;
  assign bus.flash_addr  = flash_addr_r;
  assign bus.out_layerID = id_r;
  assign bus.out_pixel   = pixel_r;
  assign bus.out_fontBit = font_r;
  assign bus.out_drawn   = drawn_r;
  assign bus.out_isText  = text_r;
  assign state_dbg       = state;

endmodule

// File: tb/tb_mem_fetch_stage.sv
// Scoreboard bench for mem_fetch_stage: random items against a behavioural memory
// model, plus directed sprite/text/no-fetch/backpressure/reset (and watchdog) cases.
module tb_mem_fetch_stage;
  localparam int RAM_AW = 26;
  localparam int TMO    = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  mem_fetch_if #(.RAM_AW(RAM_AW)) bus ();

  mem_fetch_stage #(.RAM_AW(RAM_AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Expected output word: {layerID, pixel, fontBit, drawn, isText}
  logic [42:0] exp_q[$];
  logic [25:0] exp_ram_q[$];
  logic [26:0] exp_flash_q[$];
  logic        err_model   = 1'b0;
  int          ram_force   = -1;
  int          flash_force = -1;
  int          force_stall = -1;
  bit          ram_hold    = 1'b0;

  logic [31:0] ram_mem[logic [25:0]];
  logic [7:0]  flash_mem[logic [26:0]];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [25:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return ({6'd0, a} * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [7:0] flash_byte(input logic [26:0] a);
    if (flash_mem.exists(a)) return flash_mem[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ {5'd0, a[26:24]} ^ 8'h5C;
  endfunction

  // Driver: computes the expected result from the item alone, then transfers it.
  task automatic send_item(input bit r, input bit f, input logic [7:0] id,
                           input logic [25:0] base, input logic [25:0] off,
                           input logic [29:0] fb, input bit tmo_exp);
    logic [25:0] a;
    logic [26:0] fa;
    logic [7:0]  byt;
    logic [31:0] pix;
    logic        font;
    logic        drawn;
    int          cnt;
    a     = base + off;
    fa    = fb[29:3];
    byt   = flash_byte(fa);
    pix   = (r && !tmo_exp) ? ram_word(a) : 32'd0;
    font  = (f && !tmo_exp) ? byt[7 - int'(fb[2:0])] : 1'b0;
    drawn = r && !tmo_exp && (!f || font);
    exp_q.push_back({id, pix, font, drawn, f});
    if (r) exp_ram_q.push_back(a);
    if (f && !(r && tmo_exp)) exp_flash_q.push_back(fa);
    @(negedge clk);
    bus.in_valid         = 1'b1;
    bus.readRamEn        = r;
    bus.readFlashEn      = f;
    bus.layerID          = id;
    bus.layerBase        = base;
    bus.ramAddressOffset = off;
    bus.flashAddressBits = fb;
    cnt = 0;
    while (!bus.in_ready && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    if (!bus.in_ready) begin
      check("in_ready_wait", 64'(bus.in_ready), 64'd1);
      void'(exp_q.pop_back());
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid         = 1'b0;
    bus.readRamEn        = 1'($urandom);
    bus.readFlashEn      = 1'($urandom);
    bus.layerID          = 8'($urandom);
    bus.layerBase        = 26'($urandom);
    bus.ramAddressOffset = 26'($urandom);
    bus.flashAddressBits = 30'($urandom);
  endtask

  task automatic drain(input string nm);
    int cnt;
    cnt = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    check({nm, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_ctl"}, {60'd0, bus.in_ready, bus.out_valid, bus.ram_req, bus.flash_req}, 64'h8);
    check({nm, "_fields"}, {21'd0, bus.out_layerID, bus.out_pixel, bus.out_fontBit,
                            bus.out_drawn, bus.out_isText}, 64'd0);
    check({nm, "_addr"}, {10'd0, bus.ram_addr, bus.flash_addr, bus.fetch_error}, 64'd0);
  endtask

  // RAM responder: checks the request address and acks after a random delay;
  // outside RAM_WAIT it throws spurious acks with junk data.
  initial begin
    bit          active;
    int          dly;
    logic [25:0] cap;
    active = 1'b0;
    dly = 0;
    cap = '0;
    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.ram_req && !reset) begin
        if (!active) begin
          active = 1'b1;
          dly = (ram_force >= 0) ? ram_force : int'($urandom_range(0, 4));
          cap = bus.ram_addr;
          if (exp_ram_q.size() == 0) check("ram_req_unexpected", 64'd1, 64'd0);
          else check("ram_addr", 64'(bus.ram_addr), 64'(exp_ram_q.pop_front()));
        end else begin
          check("ram_addr_stable", 64'(bus.ram_addr), 64'(cap));
        end
        if (!ram_hold && dly == 0) begin
          bus.ram_ack   = 1'b1;
          bus.ram_rdata = ram_word(cap);
        end else begin
          bus.ram_ack   = 1'b0;
          bus.ram_rdata = $urandom;
          if (dly > 0) dly--;
        end
      end else begin
        active = 1'b0;
        bus.ram_ack   = ($urandom_range(0, 3) == 0);
        bus.ram_rdata = $urandom;
      end
    end
  end

  initial begin
    bit          active;
    int          dly;
    logic [26:0] cap;
    active = 1'b0;
    dly = 0;
    cap = '0;
    bus.flash_ack   = 1'b0;
    bus.flash_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.flash_req && !reset) begin
        if (!active) begin
          active = 1'b1;
          dly = (flash_force >= 0) ? flash_force : int'($urandom_range(0, 4));
          cap = bus.flash_addr;
          if (exp_flash_q.size() == 0) check("flash_req_unexpected", 64'd1, 64'd0);
          else check("flash_addr", 64'(bus.flash_addr), 64'(exp_flash_q.pop_front()));
        end
        if (dly == 0) begin
          bus.flash_ack   = 1'b1;
          bus.flash_rdata = flash_byte(cap);
        end else begin
          bus.flash_ack   = 1'b0;
          bus.flash_rdata = 8'($urandom);
          dly--;
        end
      end else begin
        active = 1'b0;
        bus.flash_ack   = ($urandom_range(0, 3) == 0);
        bus.flash_rdata = 8'($urandom);
      end
    end
  end

  // Monitor: pops and compares on each new output, checks hold stability under backpressure.
  initial begin
    bit          holding;
    bit          hs_prev;
    int          stall;
    logic [42:0] snap;
    logic [42:0] got;
    holding = 1'b0;
    hs_prev = 1'b0;
    stall = 0;
    snap = '0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        holding = 1'b0;
        hs_prev = 1'b0;
        bus.out_ready = 1'b0;
      end else begin
        if (hs_prev) check("idle_after_handshake", {62'd0, bus.in_ready, bus.out_valid}, 64'h2);
        hs_prev = 1'b0;
        if (bus.out_valid) begin
          got = {bus.out_layerID, bus.out_pixel, bus.out_fontBit, bus.out_drawn, bus.out_isText};
          if (!holding) begin
            holding = 1'b1;
            snap = got;
            if (exp_q.size() == 0) check("out_unexpected", 64'(got), 64'd0);
            else check("out_fields", 64'(got), 64'(exp_q.pop_front()));
            check("fetch_error", 64'(bus.fetch_error), 64'(err_model));
            if (force_stall >= 0) stall = force_stall;
            else stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
          end else begin
            check("hold_stable", 64'(got), 64'(snap));
            check("hold_in_ready", 64'(bus.in_ready), 64'd0);
          end
          if (stall == 0) begin
            bus.out_ready = 1'b1;
            hs_prev = 1'b1;
            holding = 1'b0;
          end else begin
            bus.out_ready = 1'b0;
            stall--;
          end
        end else begin
          holding = 1'b0;
          bus.out_ready = 1'($urandom);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int cnt;
    reset                = 1'b1;
    bus.in_valid         = 1'b0;
    bus.readRamEn        = 1'b0;
    bus.readFlashEn      = 1'b0;
    bus.layerID          = '0;
    bus.layerBase        = '0;
    bus.ramAddressOffset = '0;
    bus.flashAddressBits = '0;
    ram_mem[26'h120]     = 32'hDEAD_BEEF;
    flash_mem[27'd1]     = 8'h10;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Sprite: 0x100 + 0x20, ack after 3 wait cycles.
    ram_force = 3;
    send_item(1'b1, 1'b0, 8'hA1, 26'h100, 26'h20, 30'h0, 1'b0);
    drain("sprite");
    ram_force = -1;

    // Text: flash addr 1, bit select 3 of 0x10.
    send_item(1'b1, 1'b1, 8'hA2, 26'h100, 26'h20, 30'h0000_000B, 1'b0);
    drain("text");

    // No fetch: output one cycle after transfer, no requests.
    send_item(1'b0, 1'b0, 8'hA3, 26'h5, 26'h6, 30'h7, 1'b0);
    @(negedge clk);
    check("nofetch_latency", {61'd0, bus.out_valid, bus.ram_req, bus.flash_req}, 64'h4);
    drain("nofetch");

    // RAM-only with ack in the entry cycle.
    ram_force = 0;
    send_item(1'b1, 1'b0, 8'hA4, 26'h3FF_FFFF, 26'h2, 30'h0, 1'b0);
    @(negedge clk);
    check("ram_lat_wait", {62'd0, bus.out_valid, bus.ram_req}, 64'h1);
    @(negedge clk);
    check("ram_lat_out", {62'd0, bus.out_valid, bus.ram_req}, 64'h2);
    drain("ram_latency");
    ram_force = -1;

    // Backpressure for 5 cycles, then flash-only text item.
    force_stall = 5;
    send_item(1'b1, 1'b1, 8'hA5, 26'($urandom), 26'($urandom), 30'($urandom), 1'b0);
    drain("backpressure");
    force_stall = -1;
    send_item(1'b0, 1'b1, 8'hA6, 26'd0, 26'd0, 30'($urandom), 1'b0);
    drain("flash_only");

    for (int i = 0; i < 200; i++) begin
      send_item(1'($urandom), 1'($urandom), 8'($urandom), 26'($urandom),
                26'($urandom), 30'($urandom), 1'b0);
    end
    drain("random");

    // Reset during RAM_WAIT: request drops at once, the item is abandoned.
    ram_hold = 1'b1;
    send_item(1'b1, 1'b0, 8'hB1, 26'h40, 26'h1, 30'h0, 1'b0);
    void'(exp_q.pop_back());
    cnt = 0;
    while (!bus.ram_req && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("midfetch_req_seen", 64'(bus.ram_req), 64'd1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midfetch_reset");
    @(negedge clk);
    reset = 1'b0;
    ram_hold = 1'b0;
    err_model = 1'b0;
    send_item(1'b0, 1'b0, 8'hB2, 26'd0, 26'd0, 30'd0, 1'b0);
    drain("after_reset");

`ifdef FETCH_TIMEOUT_EN
    // Watchdog: RAM never acks.
    ram_hold = 1'b1;
    err_model = 1'b1;
    send_item(1'b1, 1'b0, 8'hC1, 26'h77, 26'h1, 30'h0, 1'b1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.out_valid && cnt < 1000);
    check("timeout_wait_cycles", 64'(cnt), 64'(TMO + 1));
    drain("timeout");
    ram_hold = 1'b0;
    repeat (3) @(negedge clk);
    check("timeout_sticky", 64'(bus.fetch_error), 64'd1);
    reset = 1'b1;
    err_model = 1'b0;
    @(negedge clk);
    check("timeout_cleared", 64'(bus.fetch_error), 64'd0);
    reset = 1'b0;
    send_item(1'b1, 1'b0, 8'hC2, 26'h9, 26'h1, 30'h0, 1'b0);
    drain("after_timeout");
`endif

    repeat (4) @(negedge clk);
    check("addr_queues_empty", 64'(exp_ram_q.size() + exp_flash_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_fetch_stage.md
MEM_FETCH_STAGE -- requirements
Module: mem_fetch_stage

Interface
REQ-001 Parameter RAM_AW, default 26, RAM word address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, ack watchdog limit; used only with FETCH_TIMEOUT_EN.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid / in_ready  input / output  1 / 1  upstream handshake from the address-calculation stage.
REQ-006 readRamEn, readFlashEn  input  1 each  fetch enables from the address-calculation stage.
REQ-007 layerID  input  8  layer tag, passed through.
REQ-008 layerBase  input  26  RAM word base address of the current layer.
REQ-009 ramAddressOffset  input  26  RAM word offset.
REQ-010 flashAddressBits  input  30  flash bit address.
REQ-011 ram_req / ram_addr / ram_ack / ram_rdata  out 1 / out 26 / in 1 / in 32  RAM read port.
REQ-012 flash_req / flash_addr / flash_ack / flash_rdata  out 1 / out 27 / in 1 / in 8  flash byte read port.
REQ-013 out_valid / out_ready  output / input  1 / 1  downstream handshake.
REQ-014 out_layerID 8, out_pixel 32, out_fontBit 1, out_drawn 1, out_isText 1  outputs to the compositor.
REQ-015 fetch_error  output  1  sticky timeout flag.

Function
REQ-016 FSM states: IDLE, RAM_WAIT, FLASH_WAIT, OUT_HOLD.
REQ-017 in_ready is 1 only in IDLE; transfer occurs when in_valid and in_ready are both 1 on a clock edge.
REQ-018 On transfer, the stage registers all inputs; ram_addr = layerBase + ramAddressOffset, modulo 2^26.
REQ-019 On transfer, flash_addr = flashAddressBits[29:3] and the bit select = flashAddressBits[2:0].
REQ-020 Next state after transfer is RAM_WAIT if readRamEn, else FLASH_WAIT if readFlashEn, else OUT_HOLD with out_drawn = 0.
REQ-021 ram_req is high throughout RAM_WAIT; ram_addr is stable while ram_req is high.
REQ-022 ram_rdata is captured into out_pixel on the edge where ram_ack = 1; the next state is FLASH_WAIT if readFlashEn, else OUT_HOLD.
REQ-023 flash_req is high throughout FLASH_WAIT.
REQ-024 On flash_ack, out_fontBit = flash_rdata[7 - bitSelect] (MSB-first); the next state is OUT_HOLD.
REQ-025 out_isText = readFlashEn of the accepted item.
REQ-026 out_drawn = 1 if readRamEn was set and no timeout occurred.
REQ-027 For a text item, out_drawn additionally requires out_fontBit = 1.
REQ-028 out_valid is 1 only in OUT_HOLD; all out_* fields are held stable until out_ready = 1.
REQ-029 On the edge where out_valid and out_ready are both 1, the FSM returns to IDLE.
REQ-030 Minimum latency for a RAM-only item, with ack in the first wait cycle: transfer at edge N, out_valid high after edge N+1.
REQ-031 A no-fetch item reaches out_valid one cycle after transfer.
REQ-032 ram_ack or flash_ack arriving outside its wait state is ignored.
REQ-033 An ack arriving in the same cycle the state is entered is accepted.
REQ-034 out_pixel and out_fontBit are 0 for any fetch that was not performed.

Reset
REQ-035 While reset is asserted, the state is IDLE and all outputs are 0, except in_ready = 1.
REQ-036 Reset asserted mid-fetch drops ram_req and flash_req immediately; the transaction is abandoned and not replayed.
REQ-037 Reset is the only way fetch_error clears.

Configuration
REQ-038 Macro FETCH_TIMEOUT_EN: when defined, an 8-bit-or-wider wait counter runs in RAM_WAIT and FLASH_WAIT.
REQ-039 With FETCH_TIMEOUT_EN defined, after TIMEOUT_CYCLES cycles without ack the request drops and the FSM goes to OUT_HOLD with out_drawn = 0 and fetch_error set.
REQ-040 Without FETCH_TIMEOUT_EN, the stage waits indefinitely and fetch_error is tied to 0.

Verification
REQ-041 Sprite: readRamEn = 1, layerBase = 0x100, offset = 0x20, ack after 3 cycles with rdata = 0xDEADBEEF -> ram_addr = 0x120; out_pixel = 0xDEADBEEF; out_drawn = 1; out_isText = 0.
REQ-042 Text: both enables set, flashAddressBits = 0x0000_000B, flash_rdata = 0x10 -> flash_addr = 1; bit select = 3; out_fontBit = 1; out_drawn = 1.
REQ-043 No fetch: both enables 0 -> no ram_req or flash_req; out_valid one cycle after transfer; out_drawn = 0.
REQ-044 Backpressure: out_ready held 0 for 5 cycles -> outputs stable and in_ready = 0 throughout; IDLE on the handshake edge.
REQ-045 Reset asserted during RAM_WAIT -> ram_req = 0 in the same cycle; out_valid = 0; in_ready = 1.
REQ-046 FETCH_TIMEOUT_EN defined, ram_ack never asserted -> out_valid after 255 wait cycles; out_drawn = 0; fetch_error = 1 until reset.
